// File: rtl/span_filler.sv
// span_filler: queued horizontal/vertical span fill engine for a double-buffered
// 8-bit framebuffer, with a one-deep write-through path sharing the master port.
// Build option: define SPAN_FILLER_CLIP_EN to clamp spans to the visible screen
// and drop spans that start off-screen.
//
// Span geometry: a horizontal command fills row y0 from x=a to x=b; a vertical
// command fills column x=a from row y0 to row b. Either pair of endpoints may
// arrive in either order.
module span_filler #(
  parameter int SCREEN_W   = 480,
  parameter int SCREEN_H   = 272,
  parameter int COORD_W    = 9,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avs_slave_write,
  input  logic [ADDR_W:0]   avs_slave_address,
  input  logic [31:0]       avs_slave_writedata,
  input  logic [3:0]        avs_slave_byteenable,
  output logic              avs_slave_waitrequest,
  output logic              avm_fbuff_write,
  output logic [ADDR_W-1:0] avm_fbuff_address,
  output logic [31:0]       avm_fbuff_writedata,
  output logic [3:0]        avm_fbuff_byteenable,
  input  logic              avm_fbuff_waitrequest
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PIX_W = ADDR_W + 1;
  localparam logic [ADDR_W-2:0] ROW_STEP = (ADDR_W-1)'(SCREEN_W / 4);
  localparam logic [ADDR_W-2:0] COL_STEP = (ADDR_W-1)'(1);
`ifdef SPAN_FILLER_CLIP_EN
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);
`endif

  typedef struct packed {
    logic [COORD_W-1:0] y0;
    logic               bsel;
    logic [COORD_W-1:0] a;
    logic [COORD_W-1:0] b;
    logic [7:0]         colour;
    logic               vert;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, LOAD, FILL} state_t;

  state_t state_q, state_d;

  // Slave decode
  logic is_wt, is_cmd;
  cmd_t cmd_in;
  assign is_wt  = avs_slave_write &  avs_slave_address[ADDR_W];
  assign is_cmd = avs_slave_write & ~avs_slave_address[ADDR_W];

  // Unpack a command write into its fields
  always_comb begin
    cmd_in.y0     = avs_slave_address[COORD_W-1:0];
    cmd_in.bsel   = avs_slave_address[ADDR_W-1];
    cmd_in.a      = avs_slave_writedata[COORD_W-1:0];
    cmd_in.b      = avs_slave_writedata[2*COORD_W-1:COORD_W];
    cmd_in.colour = avs_slave_writedata[2*COORD_W+7:2*COORD_W];
    cmd_in.vert   = avs_slave_writedata[2*COORD_W+8];
  end

  // Command FIFO (extra pointer bit distinguishes full from empty)
  cmd_t             mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wptr_q, rptr_q;
  logic             full, empty, push, pop;
  cmd_t             cmd_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                 (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign pop   = (state_q == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign push  = is_cmd && (!full || pop);

  // Write-through holding register
  logic              hold_v_q, hold_v_d, hold_load;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [31:0]       hold_data_q;
  logic [3:0]        hold_be_q;
  assign hold_load = is_wt && !hold_v_q;

  assign avs_slave_waitrequest = (is_cmd && full && !pop) || (is_wt && hold_v_q);

  // Master output stage
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        be_q, be_d;
  logic              out_free, fill_go;
  assign out_free = !wr_q || !avm_fbuff_waitrequest;
  // Write-through takes any free beat slot ahead of the fill.
  assign fill_go  = out_free && !hold_v_q && (state_q == FILL);

  assign avm_fbuff_write      = wr_q;
  assign avm_fbuff_address    = addr_q;
  assign avm_fbuff_writedata  = data_q;
  assign avm_fbuff_byteenable = be_q;

  // Active span
  logic [ADDR_W-2:0]  word_q;
  logic [COORD_W-1:0] rem_q;
  logic               first_q, bsel_q, vert_q;
  logic [3:0]         be_first_q, be_last_q, be_mid_q;
  logic [7:0]         colour_q;
  logic [3:0]         fill_be;

  // LOAD-stage span arithmetic
  logic [COORD_W-1:0] p_lo, lo, hi, hi_c, row, col, nbeats_m1;
  logic [PIX_W-1:0]   pix;
  logic [3:0]         be_first, be_last, be_mid;
  logic               discard;
`ifdef SPAN_FILLER_CLIP_EN
  logic [COORD_W-1:0] lim;
`endif

  // Order endpoints, clip if enabled, and derive start word, beat count and masks
  always_comb begin
    p_lo = cmd_q.vert ? cmd_q.y0 : cmd_q.a;
    lo   = (p_lo <= cmd_q.b) ? p_lo : cmd_q.b;
    hi   = (p_lo <= cmd_q.b) ? cmd_q.b : p_lo;
`ifdef SPAN_FILLER_CLIP_EN
    lim     = cmd_q.vert ? Y_LIM : X_LIM;
    discard = (lo > lim);
    hi_c    = (hi > lim) ? lim : hi;
`else
    discard = 1'b0;
    hi_c    = hi;
`endif
    row = cmd_q.vert ? lo : cmd_q.y0;
    col = cmd_q.vert ? cmd_q.a : lo;
    // Truncation to PIX_W bits wraps the word address within one buffer.
    pix = PIX_W'(row) * PIX_W'(SCREEN_W) + PIX_W'(col);
    if (cmd_q.vert) begin
      nbeats_m1 = hi_c - lo;
      be_first  = 4'hF;
      be_last   = 4'hF;
      be_mid    = 4'b0001 << col[1:0];
    end else begin
      // Row base is a multiple of 4, so word span depends only on x.
      nbeats_m1 = COORD_W'(hi_c[COORD_W-1:2] - lo[COORD_W-1:2]);
      be_first  = 4'hF << lo[1:0];
      be_last   = 4'hF >> (2'd3 - hi_c[1:0]);
      be_mid    = 4'hF;
    end
  end

  logic unused_pix;
  assign unused_pix = ^pix[1:0];

  assign fill_be = be_mid_q & (first_q ? be_first_q : 4'hF) &
                   ((rem_q == '0) ? be_last_q : 4'hF);

  // Engine next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = LOAD;
      LOAD:    state_d = discard ? IDLE : FILL;
      FILL:    if (fill_go && rem_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output stage next value: hold while stalled, else write-through, else fill
  always_comb begin
    wr_d   = wr_q;
    addr_d = addr_q;
    data_d = data_q;
    be_d   = be_q;
    if (out_free) begin
      if (hold_v_q) begin
        wr_d   = 1'b1;
        addr_d = hold_addr_q;
        data_d = hold_data_q;
        be_d   = hold_be_q;
      end else if (state_q == FILL) begin
        wr_d   = 1'b1;
        addr_d = {bsel_q, word_q};
        data_d = {4{colour_q}};
        be_d   = fill_be;
      end else begin
        wr_d   = 1'b0;
      end
    end
  end

  // Holding register occupancy
  always_comb begin
    hold_v_d = hold_v_q;
    if (out_free && hold_v_q) hold_v_d = 1'b0;
    if (hold_load)            hold_v_d = 1'b1;
  end

  // FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PTR_W-1:0]] <= cmd_in;
  end

  // Control state, pointers, holding register and output stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cmd_q       <= '0;
      hold_v_q    <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      hold_be_q   <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      be_q        <= '0;
    end else begin
      state_q  <= state_d;
      hold_v_q <= hold_v_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      be_q     <= be_d;
      if (push) wptr_q <= wptr_q + (PTR_W+1)'(1);
      if (pop) begin
        rptr_q <= rptr_q + (PTR_W+1)'(1);
        cmd_q  <= mem_q[rptr_q[PTR_W-1:0]];
      end
      if (hold_load) begin
        hold_addr_q <= avs_slave_address[ADDR_W-1:0];
        hold_data_q <= avs_slave_writedata;
        hold_be_q   <= avs_slave_byteenable;
      end
    end
  end

  // Span registers: set up in LOAD, stepped once per issued fill beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q     <= '0;
      rem_q      <= '0;
      first_q    <= 1'b0;
      bsel_q     <= 1'b0;
      vert_q     <= 1'b0;
      be_first_q <= '0;
      be_last_q  <= '0;
      be_mid_q   <= '0;
      colour_q   <= '0;
    end else if (state_q == LOAD) begin
      word_q     <= pix[PIX_W-1:2];
      rem_q      <= nbeats_m1;
      first_q    <= 1'b1;
      bsel_q     <= cmd_q.bsel;
      vert_q     <= cmd_q.vert;
      be_first_q <= be_first;
      be_last_q  <= be_last;
      be_mid_q   <= be_mid;
      colour_q   <= cmd_q.colour;
    end else if (fill_go) begin
      word_q  <= word_q + (vert_q ? ROW_STEP : COL_STEP);
      rem_q   <= rem_q - COORD_W'(1);
      first_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_span_filler.sv
// Directed bench for span_filler: reset values, horizontal/vertical spans,
// single-word spans, back-to-back timing, master stalls with write-through,
// FIFO-full backpressure and reset in the middle of a span.
module tb_span_filler;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_wr = 1'b0;
  logic [ADDR_W:0]   s_addr = '0;
  logic [31:0]       s_data = '0;
  logic [3:0]        s_be = '0;
  logic              s_wait;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_data;
  logic [3:0]        m_be;
  logic              m_wait = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [ADDR_W-1:0] q_addr [$];
  logic [3:0]        q_be   [$];
  logic [31:0]       q_data [$];
  int                q_cyc  [$];

  span_filler dut (
    .clk                   (clk),
    .reset                 (rst),
    .avs_slave_write       (s_wr),
    .avs_slave_address     (s_addr),
    .avs_slave_writedata   (s_data),
    .avs_slave_byteenable  (s_be),
    .avs_slave_waitrequest (s_wait),
    .avm_fbuff_write       (m_wr),
    .avm_fbuff_address     (m_addr),
    .avm_fbuff_writedata   (m_data),
    .avm_fbuff_byteenable  (m_be),
    .avm_fbuff_waitrequest (m_wait)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // A beat presented with waitrequest low is accepted at the coming edge.
  always @(negedge clk) begin
    if (!rst && m_wr && !m_wait) begin
      q_addr.push_back(m_addr);
      q_be.push_back(m_be);
      q_data.push_back(m_data);
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [ADDR_W:0] caddr(input int y0, input int bsel);
    logic [ADDR_W:0] r;
    r = '0;
    r[ADDR_W-1] = bsel[0];
    r[8:0] = y0[8:0];
    return r;
  endfunction

  function automatic logic [31:0] cdata(input int a, input int b, input int col, input int vert);
    logic [31:0] r;
    r = '0;
    r[8:0]   = a[8:0];
    r[17:9]  = b[8:0];
    r[25:18] = col[7:0];
    r[26]    = vert[0];
    return r;
  endfunction

  task automatic clear_log();
    q_addr.delete(); q_be.delete(); q_data.delete(); q_cyc.delete();
  endtask

  task automatic slv_write(input logic [ADDR_W:0] a, input logic [31:0] d,
                           input logic [3:0] be, output int waits);
    int n;
    n = 0;
    s_wr = 1'b1; s_addr = a; s_data = d; s_be = be;
    @(negedge clk);
    while (s_wait && n < 200) begin n++; @(negedge clk); end
    waits = n;
    @(posedge clk); #1;
    s_wr = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (q_addr.size() < n && k < 200) begin @(negedge clk); #1; k++; end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_wr !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", m_wr); end
    checks++; if (m_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", m_addr); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", m_data); end
    checks++; if (m_be !== '0) begin errors++; $display("FAIL reset_be: got %b want 0", m_be); end
    checks++; if (s_wait !== 1'b0) begin errors++; $display("FAIL reset_waitreq: got %b want 0", s_wait); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_wr !== 1'b0) begin errors++; $display("FAIL post_reset_write: got %b want 0", m_wr); end
  endtask

  task automatic test_horizontal(input string nm, input int a, input int b);
    logic [ADDR_W-1:0] ea [3] = '{16'h00F1, 16'h00F2, 16'h00F3};
    logic [3:0]        eb [3] = '{4'b1110, 4'b1111, 4'b0011};
    int w;
    clear_log();
    slv_write(caddr(2, 0), cdata(a, b, 8'hAB, 0), 4'hF, w);
    wait_beats(3);
    checks++;
    if (q_addr.size() != 3) begin errors++; $display("FAIL %s_count: got %0d want 3", nm, q_addr.size()); end
    for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
      checks++;
      if (q_addr[i] !== ea[i] || q_be[i] !== eb[i] || q_data[i] !== 32'hABABABAB) begin
        errors++;
        $display("FAIL %s_beat%0d: got addr %h be %b data %h want addr %h be %b data abababab",
                 nm, i, q_addr[i], q_be[i], q_data[i], ea[i], eb[i]);
      end
    end
  endtask

  task automatic test_vertical();
    logic [ADDR_W-1:0] ea [3] = '{16'h8001, 16'h8079, 16'h80F1};
    int w;
    clear_log();
    slv_write(caddr(0, 1), cdata(6, 2, 8'h11, 1), 4'hF, w);
    wait_beats(3);
    checks++;
    if (q_addr.size() != 3) begin errors++; $display("FAIL vert_count: got %0d want 3", q_addr.size()); end
    for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
      checks++;
      if (q_addr[i] !== ea[i] || q_be[i] !== 4'b0100 || q_data[i] !== 32'h11111111) begin
        errors++;
        $display("FAIL vert_beat%0d: got addr %h be %b data %h want addr %h be 0100 data 11111111",
                 i, q_addr[i], q_be[i], q_data[i], ea[i]);
      end
    end
  endtask

  // Two single-word spans queued together; also measures the idle gap.
  task automatic test_back_to_back();
    int w;
    int gap;
    clear_log();
    slv_write(caddr(1, 0), cdata(7, 7, 8'h5A, 0), 4'hF, w);
    slv_write(caddr(0, 0), cdata(4, 6, 8'h5A, 0), 4'hF, w);
    wait_beats(2);
    checks++;
    if (q_addr.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", q_addr.size()); end
    else begin
      checks++;
      if (q_addr[0] !== 16'h0079 || q_be[0] !== 4'b1000) begin
        errors++; $display("FAIL single_pixel: got addr %h be %b want addr 0079 be 1000", q_addr[0], q_be[0]);
      end
      checks++;
      if (q_addr[1] !== 16'h0001 || q_be[1] !== 4'b0111) begin
        errors++; $display("FAIL single_word: got addr %h be %b want addr 0001 be 0111", q_addr[1], q_be[1]);
      end
      gap = q_cyc[1] - q_cyc[0] - 1;
      checks++;
      if (gap > 2) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles want at most 2", gap); end
    end
  endtask

  task automatic test_waitrequest();
    logic [ADDR_W-1:0] ea [4] = '{16'h00F1, 16'h00F2, 16'h1234, 16'h00F3};
    int w;
    int n;
    clear_log();
    slv_write(caddr(2, 0), cdata(5, 13, 8'hAB, 0), 4'hF, w);
    n = 0;
    while (q_addr.size() < 1 && n < 100) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    // Beat 2 is now on the bus: stall it and present a write-through.
    m_wait = 1'b1;
    s_wr = 1'b1; s_addr = 17'h11234; s_data = 32'hDEADBEEF; s_be = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (s_wait !== 1'b0) begin errors++; $display("FAIL wt_accept: got waitreq %b want 0", s_wait); end
      end
      checks++;
      if (m_wr !== 1'b1 || m_addr !== 16'h00F2 || m_be !== 4'hF || m_data !== 32'hABABABAB) begin
        errors++;
        $display("FAIL stall_hold%0d: got wr %b addr %h be %b data %h want wr 1 addr 00f2 be 1111 data abababab",
                 k, m_wr, m_addr, m_be, m_data);
      end
      @(posedge clk); #1;
      s_wr = 1'b0;
    end
    m_wait = 1'b0;
    wait_beats(4);
    checks++;
    if (q_addr.size() != 4) begin errors++; $display("FAIL wt_count: got %0d want 4", q_addr.size()); end
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      checks++;
      if (q_addr[i] !== ea[i]) begin
        errors++; $display("FAIL wt_order%0d: got addr %h want %h", i, q_addr[i], ea[i]);
      end
    end
    if (q_addr.size() == 4) begin
      checks++;
      if (q_data[2] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL wt_data: got %h want deadbeef", q_data[2]);
      end
    end
  endtask

  task automatic test_fifo_full();
    int w;
    int n;
    clear_log();
    m_wait = 1'b1;
    // Engine takes this one and sticks on its first beat.
    slv_write(caddr(2, 0), cdata(5, 13, 8'hAB, 0), 4'hF, w);
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      slv_write(caddr(10 + i, 0), cdata(i * 4, i * 4, 8'h20 + i, 0), 4'hF, w);
      checks++;
      if (w != 0) begin errors++; $display("FAIL fifo_push%0d: got %0d wait cycles want 0", i, w); end
    end
    s_wr = 1'b1; s_addr = caddr(20, 0); s_data = cdata(8, 8, 8'h30, 0); s_be = 4'hF;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (s_wait !== 1'b1) begin errors++; $display("FAIL fifo_full_wait: got %b want 1", s_wait); end
    end
    @(posedge clk); #1;
    m_wait = 1'b0;
    n = 0;
    @(negedge clk);
    while (s_wait && n < 50) begin n++; @(negedge clk); end
    checks++;
    if (s_wait !== 1'b0) begin errors++; $display("FAIL fifo_drain: got waitreq %b want 0", s_wait); end
    @(posedge clk); #1;
    s_wr = 1'b0;
    wait_beats(8);
    checks++;
    if (q_addr.size() != 8) begin errors++; $display("FAIL fifo_beats: got %0d want 8", q_addr.size()); end
    else begin
      checks++;
      if (q_addr[7] !== 16'h0962 || q_data[7] !== 32'h30303030) begin
        errors++; $display("FAIL fifo_last: got addr %h data %h want addr 0962 data 30303030", q_addr[7], q_data[7]);
      end
    end
  endtask

  task automatic test_reset_midfill();
    int w;
    int n;
    clear_log();
    slv_write(caddr(2, 0), cdata(5, 13, 8'hAB, 0), 4'hF, w);
    n = 0;
    while (q_addr.size() < 1 && n < 100) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    checks++;
    if (m_wr !== 1'b1 || m_addr !== 16'h00F2) begin
      errors++; $display("FAIL midfill_beat2: got wr %b addr %h want wr 1 addr 00f2", m_wr, m_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_wr !== 1'b0 || m_addr !== '0 || m_be !== '0) begin
      errors++; $display("FAIL midfill_async: got wr %b addr %h be %b want 0 0 0", m_wr, m_addr, m_be);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (q_addr.size() != 1) begin errors++; $display("FAIL midfill_abandon: got %0d beats want 1", q_addr.size()); end
    slv_write(caddr(1, 0), cdata(7, 7, 8'h44, 0), 4'hF, w);
    wait_beats(2);
    checks++;
    if (q_addr.size() != 2 || q_addr[q_addr.size()-1] !== 16'h0079) begin
      errors++; $display("FAIL midfill_restart: got %0d beats last %h want 2 beats last 0079",
                         q_addr.size(), q_addr[q_addr.size()-1]);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal("horiz", 5, 13);
    test_horizontal("swapped", 13, 5);
    test_vertical();
    test_back_to_back();
    test_waitrequest();
    test_fifo_full();
    test_reset_midfill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
